ad80305_rx_deframer: RTL and testbench

- Parametrised successor to the single-channel AD80305 RX frame splitter.
- Sits in the FPGA clock domain, downstream of the IDDR capture and CDC FIFO.
- Input: DDR beat pairs, each beat carrying a 12-bit sample plus a frame bit. Output: aligned I/Q sample sets for 1..4 receive channels.
- Adds what the old splitter lacks: frame-lock FSM with verification, frame-error detection, resync, and per-set valid strobe.

---
 rtl/ad80305_rx_pkg.sv | 34 +++
 rtl/ad80305_rx_lock_fsm.sv | 120 ++++++++++++
 rtl/ad80305_rx_deframer.sv | 134 +++++++++++++
 tb/tb_ad80305_rx_deframer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad80305_rx_pkg.sv
// Shared types and constants for the AD80305 RX deframer.
package ad80305_rx_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } rx_state_t;

  localparam int unsigned RX_DW_DEF    = 12;
  localparam int unsigned RX_FRAME_BIT = RX_DW_DEF;   // frame bit sits just above the sample
  localparam int unsigned RX_MAX_NCH   = 4;
  localparam int unsigned RX_ERR_CNT_W = 16;
  localparam int unsigned RX_IDX_W     = $clog2(2 * RX_MAX_NCH);
  localparam int unsigned RX_VCNT_W    = 4;           // holds LOCK_SETS up to 15

  // Lock tracker context carried from beat to beat
  typedef struct packed {
    rx_state_t             st;
    logic [RX_IDX_W-1:0]   idx;
    logic [RX_VCNT_W-1:0]  vcnt;
    logic                  prev;
  } rx_ctx_t;

  // Result of processing one beat
  typedef struct packed {
    rx_ctx_t               ctx;
    logic                  wr;
    logic [RX_IDX_W-1:0]   widx;
    logic                  done;
    logic                  err;
  } rx_step_t;

endpackage

// File: rtl/ad80305_rx_lock_fsm.sv
// Frame-lock tracker: state, beat index and verify counter, fed two frame
// bits per cycle (h first, then l). Emits per-beat slot writes and flags.
module ad80305_rx_lock_fsm
  import ad80305_rx_pkg::*;
#(
  parameter int unsigned NCH       = 2,
  parameter int unsigned LOCK_SETS = 4
) (
  input  logic                i_fpga_clk_125p,
  input  logic                i_fpga_rst_125p,
  input  logic                beat_vld,
  input  logic                frame_h,
  input  logic                frame_l,
  input  logic                resync,
  output logic                wr_h,
  output logic [RX_IDX_W-1:0] widx_h,
  output logic                wr_l,
  output logic [RX_IDX_W-1:0] widx_l,
  output logic                done_h,
  output logic                done_l,
  output logic                frame_err,
  output logic                locked
);

  localparam logic [RX_IDX_W-1:0]  NCH_I = RX_IDX_W'(NCH);
  localparam logic [RX_IDX_W-1:0]  LAST  = RX_IDX_W'(2 * NCH - 1);
  localparam logic [RX_VCNT_W-1:0] VLAST = RX_VCNT_W'(LOCK_SETS - 1);

  rx_ctx_t  ctx_q, ctx_d;
  rx_step_t s_h, s_l;

  // One beat through the lock tracker
  function automatic rx_step_t step(input rx_ctx_t c, input logic f);
    rx_step_t r;
    r          = '0;
    r.ctx      = c;
    r.ctx.prev = f;
    if (c.st == ST_SEARCH) begin
      if (!c.prev && f) begin
        r.wr       = 1'b1;
        r.widx     = '0;
        r.ctx.idx  = RX_IDX_W'(1);
        r.ctx.st   = ST_VERIFY;
        r.ctx.vcnt = '0;
      end
    end else if (f != (c.idx < NCH_I)) begin
      r.err      = 1'b1;
      r.ctx.st   = ST_SEARCH;
      r.ctx.idx  = '0;
      r.ctx.vcnt = '0;
    end else begin
      r.wr   = 1'b1;
      r.widx = c.idx;
      if (c.idx == LAST) begin
        r.ctx.idx = '0;
        if (c.st == ST_VERIFY) begin
          if (c.vcnt == VLAST) begin
            r.ctx.st   = ST_LOCKED;
            r.ctx.vcnt = '0;
          end else begin
            r.ctx.vcnt = c.vcnt + 1'b1;
          end
        end else begin
          r.done = 1'b1;
        end
      end else begin
        r.ctx.idx = c.idx + 1'b1;
      end
    end
    return r;
  endfunction

  // Context register
  always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_125p) begin
    if (!i_fpga_rst_125p) begin
      ctx_q    <= '0;
      ctx_q.st <= ST_SEARCH;
    end else begin
      ctx_q <= ctx_d;
    end
  end

  // Next context and per-beat strobes; an error ends the cycle's processing,
  // so the l beat after an h error only refreshes the previous-frame bit
  always_comb begin
    ctx_d     = ctx_q;
    wr_h      = 1'b0;
    widx_h    = '0;
    wr_l      = 1'b0;
    widx_l    = '0;
    done_h    = 1'b0;
    done_l    = 1'b0;
    frame_err = 1'b0;
    s_h       = step(ctx_q, frame_h);
    if (s_h.err) begin
      s_l          = '0;
      s_l.ctx      = s_h.ctx;
      s_l.ctx.prev = frame_l;
    end else begin
      s_l = step(s_h.ctx, frame_l);
    end
    if (resync) begin
      ctx_d      = '0;
      ctx_d.st   = ST_SEARCH;
      ctx_d.prev = beat_vld ? frame_l : ctx_q.prev;
    end else if (beat_vld) begin
      ctx_d     = s_l.ctx;
      wr_h      = s_h.wr;
      widx_h    = s_h.widx;
      wr_l      = s_l.wr;
      widx_l    = s_l.widx;
      frame_err = s_h.err | s_l.err;
      done_h    = s_h.done & ~frame_err;
      done_l    = s_l.done & ~frame_err;
    end
  end

  assign locked = (ctx_q.st == ST_LOCKED);

endmodule

// File: rtl/ad80305_rx_deframer.sv
// AD80305 RX deframer: splits DDR beat pairs into aligned I/Q sets for
// NCH channels behind a frame-lock tracker.
// Optional frame-error counter: define AD80305_RX_ERRCNT_EN.
module ad80305_rx_deframer
  import ad80305_rx_pkg::*;
#(
  parameter int unsigned DW        = RX_DW_DEF,
  parameter int unsigned NCH       = 2,
  parameter int unsigned LOCK_SETS = 4
) (
  input  logic                    i_fpga_clk_125p,
  input  logic                    i_fpga_rst_125p,
  input  logic                    i_beat_vld,
  input  logic [DW:0]             i_beat_h,
  input  logic [DW:0]             i_beat_l,
  input  logic                    i_resync,
  output logic                    o_iq_vld,
  output logic [NCH*DW-1:0]       o_idata,
  output logic [NCH*DW-1:0]       o_qdata,
  output logic                    o_locked,
  output logic                    o_frame_err,
  output logic [RX_ERR_CNT_W-1:0] o_err_cnt
);

  localparam int unsigned FB = DW;
  localparam int unsigned NS = 2 * NCH;

  logic                wr_h, wr_l, done_h, done_l, frame_err, locked;
  logic [RX_IDX_W-1:0] widx_h, widx_l;
  logic [DW-1:0]       slot_q   [NS];
  logic [DW-1:0]       slot_mid [NS];
  logic [DW-1:0]       slot_nxt [NS];
  logic [DW-1:0]       set_src  [NS];
  logic [NCH*DW-1:0]   pack_i, pack_q;
  logic [NCH*DW-1:0]   idata_q, qdata_q;
  logic                iq_vld_q, ferr_q;

  ad80305_rx_lock_fsm #(
    .NCH       (NCH),
    .LOCK_SETS (LOCK_SETS)
  ) u_lock (
    .i_fpga_clk_125p (i_fpga_clk_125p),
    .i_fpga_rst_125p (i_fpga_rst_125p),
    .beat_vld        (i_beat_vld),
    .frame_h         (i_beat_h[FB]),
    .frame_l         (i_beat_l[FB]),
    .resync          (i_resync),
    .wr_h            (wr_h),
    .widx_h          (widx_h),
    .wr_l            (wr_l),
    .widx_l          (widx_l),
    .done_h          (done_h),
    .done_l          (done_l),
    .frame_err       (frame_err),
    .locked          (locked)
  );

  // Slot image after the h write and after the l write; a set closed by h
  // must be taken from the mid image before l starts the next set
  always_comb begin
    slot_mid = slot_q;
    for (int unsigned s = 0; s < NS; s++) begin
      if (wr_h && widx_h == RX_IDX_W'(s)) slot_mid[s] = i_beat_h[DW-1:0];
    end
    slot_nxt = slot_mid;
    for (int unsigned s = 0; s < NS; s++) begin
      if (wr_l && widx_l == RX_IDX_W'(s)) slot_nxt[s] = i_beat_l[DW-1:0];
    end
  end

  // Even slots to I, odd slots to Q, from whichever image closed the set
  always_comb begin
    set_src = slot_nxt;
    if (done_h) set_src = slot_mid;
    pack_i = '0;
    pack_q = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      pack_i[k*DW +: DW] = set_src[2*k];
      pack_q[k*DW +: DW] = set_src[2*k+1];
    end
  end

  // Slot storage
  always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_125p) begin
    if (!i_fpga_rst_125p) begin
      for (int unsigned s = 0; s < NS; s++) slot_q[s] <= '0;
    end else begin
      slot_q <= slot_nxt;
    end
  end

  // Output registers: data held between strobes
  always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_125p) begin
    if (!i_fpga_rst_125p) begin
      iq_vld_q <= 1'b0;
      ferr_q   <= 1'b0;
      idata_q  <= '0;
      qdata_q  <= '0;
    end else begin
      iq_vld_q <= done_h | done_l;
      ferr_q   <= frame_err;
      if (done_h || done_l) begin
        idata_q <= pack_i;
        qdata_q <= pack_q;
      end
    end
  end

  assign o_iq_vld    = iq_vld_q;
  assign o_idata     = idata_q;
  assign o_qdata     = qdata_q;
  assign o_frame_err = ferr_q;
  assign o_locked    = locked;

`ifdef AD80305_RX_ERRCNT_EN
  logic [RX_ERR_CNT_W-1:0] err_cnt_q;

  // Saturating frame-error counter, cleared by resync
  always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_125p) begin
    if (!i_fpga_rst_125p) begin
      err_cnt_q <= '0;
    end else if (i_resync) begin
      err_cnt_q <= '0;
    end else if (frame_err && err_cnt_q != '1) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign o_err_cnt = err_cnt_q;
`else
  assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_ad80305_rx_deframer.sv
// Bench for ad80305_rx_deframer: NCH=2 and NCH=1 instances, table-driven
// lock/error sequence plus hand sequences, I/Q sets checked by scoreboard.
module tb_ad80305_rx_deframer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        vld2, rsy2, vld1, rsy1;
  logic [12:0] h2, l2, h1, l1;
  logic        iqv2, lk2, fe2, iqv1, lk1, fe1;
  logic [23:0] idat2, qdat2;
  logic [11:0] idat1, qdat1;
  logic [15:0] ec2, ec1;

  ad80305_rx_deframer #(.DW(12), .NCH(2), .LOCK_SETS(4)) dut2 (
    .i_fpga_clk_125p (clk),
    .i_fpga_rst_125p (rst_n),
    .i_beat_vld      (vld2),
    .i_beat_h        (h2),
    .i_beat_l        (l2),
    .i_resync        (rsy2),
    .o_iq_vld        (iqv2),
    .o_idata         (idat2),
    .o_qdata         (qdat2),
    .o_locked        (lk2),
    .o_frame_err     (fe2),
    .o_err_cnt       (ec2)
  );

  ad80305_rx_deframer #(.DW(12), .NCH(1), .LOCK_SETS(4)) dut1 (
    .i_fpga_clk_125p (clk),
    .i_fpga_rst_125p (rst_n),
    .i_beat_vld      (vld1),
    .i_beat_h        (h1),
    .i_beat_l        (l1),
    .i_resync        (rsy1),
    .o_iq_vld        (iqv1),
    .o_idata         (idat1),
    .o_qdata         (qdat1),
    .o_locked        (lk1),
    .o_frame_err     (fe1),
    .o_err_cnt       (ec1)
  );

`ifdef AD80305_RX_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  typedef struct {
    int          at;
    logic [23:0] ei;
    logic [23:0] eq;
  } exp_t;

  typedef struct {
    logic        vld;
    logic [12:0] h;
    logic [12:0] l;
    logic        rsy;
    logic        exp_locked;
    logic        exp_ferr;
    logic        push;
    logic [23:0] ei;
    logic [23:0] eq;
  } vec_t;

  exp_t sb2[$];
  exp_t sb1[$];
  int   nchk  = 0;
  int   nerr  = 0;
  int   neg_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_cnt(input int n);
    return ERRCNT ? 16'(n) : 16'd0;
  endfunction

  function automatic vec_t mk(input logic [12:0] h, input logic [12:0] l, input logic lk,
                              input logic fe, input logic ps, input logic [23:0] ei,
                              input logic [23:0] eq);
    vec_t v;
    v.vld = 1'b1; v.h = h; v.l = l; v.rsy = 1'b0;
    v.exp_locked = lk; v.exp_ferr = fe; v.push = ps; v.ei = ei; v.eq = eq;
    return v;
  endfunction

  function automatic logic [11:0] isamp(input int m);
    logic [11:0] r;
    r = 12'h100 + 12'(m);
    return r;
  endfunction

  function automatic logic [11:0] qsamp(input int m);
    logic [11:0] r;
    r = 12'h800 + 12'(m);
    return r;
  endfunction

  // Scoreboard monitor for one instance; strobe due two negedges after drive
  task automatic mon(input int id, input logic v, input logic [23:0] di, input logic [23:0] dq);
    bit   have;
    exp_t e;
    have = (id == 2) ? (sb2.size() > 0) : (sb1.size() > 0);
    if (have) e = (id == 2) ? sb2[0] : sb1[0];
    if (v) begin
      if (!have) begin
        nchk++; nerr++;
        $display("FAIL unexpected_strobe dut%0d: o_iq_vld=1 expected 0 at cycle %0d", id, neg_n);
      end else begin
        if (id == 2) void'(sb2.pop_front()); else void'(sb1.pop_front());
        chk($sformatf("dut%0d_strobe_cycle", id), neg_n, e.at);
        chk($sformatf("dut%0d_o_idata", id), di, e.ei);
        chk($sformatf("dut%0d_o_qdata", id), dq, e.eq);
      end
    end else if (have && e.at < neg_n) begin
      if (id == 2) void'(sb2.pop_front()); else void'(sb1.pop_front());
      nchk++; nerr++;
      $display("FAIL missing_strobe dut%0d: o_iq_vld=0 expected 1 at cycle %0d", id, e.at);
    end
  endtask

  always @(negedge clk) begin
    neg_n++;
    if (rst_n) begin
      mon(2, iqv2, idat2, qdat2);
      mon(1, iqv1, {12'h0, idat1}, {12'h0, qdat1});
    end
  end

  task automatic push2(input logic [23:0] ei, input logic [23:0] eq);
    sb2.push_back('{neg_n + 2, ei, eq});
  endtask

  task automatic push1(input logic [11:0] ei, input logic [11:0] eq);
    sb1.push_back('{neg_n + 2, {12'h0, ei}, {12'h0, eq}});
  endtask

  task automatic cyc2(input logic v, input logic [12:0] h, input logic [12:0] l, input logic r);
    vld2 = v; h2 = h; l2 = l; rsy2 = r;
    @(posedge clk); #1;
  endtask

  task automatic cyc1(input logic v, input logic [12:0] h, input logic [12:0] l, input logic r);
    vld1 = v; h1 = h; l1 = l; rsy1 = r;
    @(posedge clk); #1;
  endtask

  // NCH=1 stream offset by one beat so every set starts on l
  task automatic run1(input int base, input int ncyc);
    for (int n = 0; n < ncyc; n++) begin
      logic [12:0] h, l;
      h = (n == 0) ? {1'b0, 12'hFA0} : {1'b0, qsamp(base + n - 1)};
      l = {1'b1, isamp(base + n)};
      if (n >= 5) push1(isamp(base + n - 1), qsamp(base + n - 1));
      cyc1(1'b1, h, l, 1'b0);
      chk($sformatf("dut1_run%0d_locked_%0d", base, n), lk1, n >= 4);
      chk($sformatf("dut1_run%0d_ferr_%0d", base, n), fe1, 1'b0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dut2_locked"}, lk2, 1'b0);
    chk({tag, "_dut2_iq_vld"}, iqv2, 1'b0);
    chk({tag, "_dut2_idata"}, idat2, 24'h0);
    chk({tag, "_dut2_qdata"}, qdat2, 24'h0);
    chk({tag, "_dut2_ferr"}, fe2, 1'b0);
    chk({tag, "_dut2_errcnt"}, ec2, 16'h0);
    chk({tag, "_dut1_locked"}, lk1, 1'b0);
    chk({tag, "_dut1_iq_vld"}, iqv1, 1'b0);
    chk({tag, "_dut1_idata"}, idat1, 12'h0);
    chk({tag, "_dut1_qdata"}, qdat1, 12'h0);
    chk({tag, "_dut1_ferr"}, fe1, 1'b0);
    chk({tag, "_dut1_errcnt"}, ec1, 16'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[26];
    int   n;

    // NCH=2 lock, steady output, Q2 frame error, relock
    n = 0;
    for (int s = 0; s < 4; s++) begin
      tbl[n] = mk({1'b1, 12'h101}, {1'b1, 12'h202}, 1'b0, 1'b0, 1'b0, '0, '0); n++;
      tbl[n] = mk({1'b0, 12'h303}, {1'b0, 12'h404}, s == 3, 1'b0, 1'b0, '0, '0); n++;
    end
    tbl[n] = mk({1'b1, 12'h101}, {1'b1, 12'h202}, 1'b1, 1'b0, 1'b0, '0, '0); n++;
    tbl[n] = mk({1'b0, 12'h303}, {1'b0, 12'h404}, 1'b1, 1'b0, 1'b1, 24'h303101, 24'h404202); n++;
    tbl[n] = mk({1'b1, 12'h111}, {1'b1, 12'h222}, 1'b1, 1'b0, 1'b0, '0, '0); n++;
    tbl[n] = mk({1'b0, 12'h333}, {1'b0, 12'h444}, 1'b1, 1'b0, 1'b1, 24'h333111, 24'h444222); n++;
    tbl[n] = mk({1'b1, 12'h555}, {1'b1, 12'h666}, 1'b1, 1'b0, 1'b0, '0, '0); n++;
    tbl[n] = mk({1'b0, 12'h777}, {1'b1, 12'h888}, 1'b0, 1'b1, 1'b0, '0, '0); n++;
    tbl[n] = mk({1'b1, 12'h121}, {1'b1, 12'h232}, 1'b0, 1'b0, 1'b0, '0, '0); n++;
    tbl[n] = mk({1'b0, 12'h343}, {1'b0, 12'h454}, 1'b0, 1'b0, 1'b0, '0, '0); n++;
    for (int s = 0; s < 4; s++) begin
      tbl[n] = mk({1'b1, 12'h9A1}, {1'b1, 12'h9B2}, 1'b0, 1'b0, 1'b0, '0, '0); n++;
      tbl[n] = mk({1'b0, 12'h9C3}, {1'b0, 12'h9D4}, s == 3, 1'b0, 1'b0, '0, '0); n++;
    end
    tbl[n] = mk({1'b1, 12'h0A1}, {1'b1, 12'h0B2}, 1'b1, 1'b0, 1'b0, '0, '0); n++;
    tbl[n] = mk({1'b0, 12'h0C3}, {1'b0, 12'h0D4}, 1'b1, 1'b0, 1'b1, 24'h0C30A1, 24'h0D40B2); n++;

    rst_n = 1'b0;
    vld2 = 1'b0; rsy2 = 1'b0; h2 = '0; l2 = '0;
    vld1 = 1'b0; rsy1 = 1'b0; h1 = '0; l1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < n; i++) begin
      if (tbl[i].push) push2(tbl[i].ei, tbl[i].eq);
      cyc2(tbl[i].vld, tbl[i].h, tbl[i].l, tbl[i].rsy);
      chk($sformatf("vec%0d_locked", i), lk2, tbl[i].exp_locked);
      chk($sformatf("vec%0d_frame_err", i), fe2, tbl[i].exp_ferr);
    end
    chk("errcnt_after_table", ec2, exp_cnt(1));

    // Set assembled across vld gaps; junk on idle cycles must be ignored
    cyc2(1'b1, {1'b1, 12'h011}, {1'b1, 12'h022}, 1'b0);
    cyc2(1'b0, {1'b0, 12'hFFF}, {1'b1, 12'hEEE}, 1'b0);
    cyc2(1'b0, {1'b1, 12'hDDD}, {1'b0, 12'hCCC}, 1'b0);
    push2(24'h033011, 24'h044022);
    cyc2(1'b1, {1'b0, 12'h033}, {1'b0, 12'h044}, 1'b0);
    chk("gap_locked", lk2, 1'b1);
    chk("gap_ferr", fe2, 1'b0);

    // Resync on the cycle that would close a locked set
    cyc2(1'b1, {1'b1, 12'h0AB}, {1'b1, 12'h0CD}, 1'b0);
    cyc2(1'b1, {1'b0, 12'h0EF}, {1'b0, 12'h0F0}, 1'b1);
    chk("resync_locked", lk2, 1'b0);
    chk("resync_ferr", fe2, 1'b0);
    chk("resync_errcnt", ec2, 16'h0);
    cyc2(1'b0, '0, '0, 1'b0);
    cyc2(1'b1, {1'b1, 12'h0AB}, {1'b1, 12'h0CD}, 1'b0);
    cyc2(1'b1, {1'b0, 12'h0EF}, {1'b0, 12'h0F0}, 1'b0);
    chk("verify_not_locked", lk2, 1'b0);

    // Three errors in VERIFY (I2 frame bit set)
    for (int e = 1; e <= 3; e++) begin
      cyc2(1'b1, {1'b1, 12'h1E0}, {1'b1, 12'h1E1}, 1'b0);
      chk($sformatf("err%0d_pre_ferr", e), fe2, 1'b0);
      cyc2(1'b1, {1'b1, 12'h2E0}, {1'b0, 12'h2E1}, 1'b0);
      chk($sformatf("err%0d_ferr", e), fe2, 1'b1);
      chk($sformatf("err%0d_errcnt", e), ec2, exp_cnt(e));
    end
    cyc2(1'b0, '0, '0, 1'b1);
    chk("errcnt_cleared", ec2, 16'h0);
    chk("errcnt_clear_locked", lk2, 1'b0);
    cyc2(1'b0, '0, '0, 1'b0);

    // NCH=1, sets start on l; one set per cycle once locked
    run1(0, 10);
    // Set closes on h while l breaks framing: error wins, no strobe
    cyc1(1'b1, {1'b0, qsamp(9)}, {1'b0, 12'h555}, 1'b0);
    chk("dut1_err_ferr", fe1, 1'b1);
    chk("dut1_err_locked", lk1, 1'b0);
    chk("dut1_err_errcnt", ec1, exp_cnt(1));
    run1(20, 8);
    cyc1(1'b0, '0, '0, 1'b0);

    // Reset in the middle of a set
    rst_n = 1'b0;
    #2;
    chk_all_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc1(1'b1, {1'b0, qsamp(27)}, {1'b0, 12'h777}, 1'b0);
    chk("post_reset_locked_a", lk1, 1'b0);
    cyc1(1'b1, {1'b0, 12'h001}, {1'b1, 12'h002}, 1'b0);
    cyc1(1'b1, {1'b0, 12'h003}, {1'b1, 12'h004}, 1'b0);
    chk("post_reset_locked_b", lk1, 1'b0);
    repeat (3) cyc1(1'b0, '0, '0, 1'b0);

    chk("sb2_drained", sb2.size(), 0);
    chk("sb1_drained", sb1.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
